// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register pending-load scoreboard driving the decode stall (optional LOAD_SCOREBOARD_TIMEOUT_EN)
`ifndef HBIT_OPC
`define HBIT_OPC 5
`endif
`ifndef OPC_LDur
`define OPC_LDur 6'h10
`endif
`ifndef OPC_LDso
`define OPC_LDso 6'h11
`endif
`ifndef OPC_SRLDso
`define OPC_SRLDso 6'h12
`endif

module load_scoreboard #(
    parameter int NREG    = 16,
    parameter int RBITS   = 4,
    parameter int MAX_OUT = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic [`HBIT_OPC:0] iw_idex_opc,
    input  logic [RBITS-1:0]  iw_idex_tgt,
    input  logic              iw_idex_valid,
    input  logic [RBITS-1:0]  iw_dec_src_a,
    input  logic              iw_dec_src_a_en,
    input  logic [RBITS-1:0]  iw_dec_src_b,
    input  logic              iw_dec_src_b_en,
    input  logic [RBITS-1:0]  iw_dec_tgt,
    input  logic              iw_dec_tgt_en,
    input  logic              iw_dec_is_load,
    input  logic              iw_ret_valid,
    input  logic [RBITS-1:0]  iw_ret_tgt,
    output logic              ow_stall,
    output logic [NREG-1:0]   ow_busy,
    output logic [2:0]        ow_count,
    output logic              ow_full,
    output logic              ow_err
);

    localparam logic [2:0] MAX_C = 3'(MAX_OUT);

    // Parameter sanity: count is 3 bits and the idle counter is 4 bits.
    if (MAX_OUT < 1 || MAX_OUT > 7 || TIMEOUT < 1 || TIMEOUT > 15 || NREG != (1 << RBITS)) begin : g_bad_params
        $error("load_scoreboard: parameter out of range");
    end

    logic [NREG-1:0] busy_q, busy_d;
    logic [2:0]      count_q, count_d;
    logic            err_q, err_d;
    logic            issue, ret, spurious, overflow, timeout_hit;
    logic [3:0]      inflight_sum;

    // Classify this cycle's ID/EX and writeback events.
    always_comb begin
        issue    = iw_idex_valid && (iw_idex_opc == `OPC_LDur || iw_idex_opc == `OPC_LDso ||
                                     iw_idex_opc == `OPC_SRLDso);
        ret      = iw_ret_valid && busy_q[iw_ret_tgt];
        spurious = iw_ret_valid && !busy_q[iw_ret_tgt];
        overflow = issue && (count_q == MAX_C);
    end

`ifdef LOAD_SCOREBOARD_TIMEOUT_EN
    localparam logic [3:0] TO_C = 4'(TIMEOUT);
    logic [3:0] idle_q, idle_d;

    // Idle counter: cycles with loads pending and no return; flushes the scoreboard on expiry.
    always_comb begin
        timeout_hit = (count_q != 3'd0) && !ret && (idle_q == TO_C);
        idle_d      = idle_q + 4'd1;
        if (count_q == 3'd0 || ret || timeout_hit) idle_d = 4'd0;
    end

    // Idle counter register.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) idle_q <= 4'd0;
        else        idle_q <= idle_d;
    end
`else
    always_comb timeout_hit = 1'b0;
`endif

    // Next-state for busy bits, in-flight count and sticky error; issue wins over return on the same register.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        err_d   = err_q;
        if (spurious || overflow) err_d = 1'b1;
        if (ret)   busy_d[iw_ret_tgt]  = 1'b0;
        if (issue) busy_d[iw_idex_tgt] = 1'b1;
        if (issue && !ret && !overflow) count_d = count_q + 3'd1;
        else if (ret && !issue)         count_d = count_q - 3'd1;
        if (timeout_hit) begin
            busy_d  = '0;
            count_d = 3'd0;
            err_d   = 1'b1;
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            busy_q  <= '0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Decode stall: registered hazards plus the load currently in ID/EX, whose bit is not yet set.
    always_comb begin
        inflight_sum = {1'b0, count_q} + {3'd0, issue};
        ow_stall = (iw_dec_src_a_en && busy_q[iw_dec_src_a])
                || (iw_dec_src_b_en && busy_q[iw_dec_src_b])
                || (issue && iw_dec_src_a_en && iw_idex_tgt == iw_dec_src_a)
                || (issue && iw_dec_src_b_en && iw_idex_tgt == iw_dec_src_b)
                || (iw_dec_tgt_en && (busy_q[iw_dec_tgt] || (issue && iw_idex_tgt == iw_dec_tgt)))
                || (iw_dec_is_load && inflight_sum >= {1'b0, MAX_C});
        ow_busy  = busy_q;
        ow_count = count_q;
        ow_full  = (count_q == MAX_C);
        ow_err   = err_q;
    end

endmodule
